ingreso_clave: RTL and testbench
================================

# ingreso_clave

Keypad entry front end for the gate access controller. Assembles four BCD digits from single-cycle keypad strobes, supports backspace, clear, enter, and an inactivity timeout. Delivers the finished 16-bit BCD PIN to the access controller over a valid/ack handshake. It is the producer of the `clave` bus the controller compares against its stored PIN. It is enabled only while the controller is in its PIN-attempt state.

## Interface
- `TIMEOUT_CICLOS`, default 1000: number of idle cycles in CAPTURA, with at least one digit buffered, before the buffer is discarded. Legal range ≥ 2.
- `clk`  in  1  clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `habilitar`  in  1  high while the controller accepts PIN attempts. Low forces IDLE.
- `tecla_valida`  in  1  one-cycle strobe; `tecla` is valid in this cycle.
- `tecla`  in  4  key code:
  - 0–9: digits
  - 4'hA: borrar (backspace)
  - 4'hB: limpiar (clear)
  - 4'hC: enter
  - 4'hD–4'hF: illegal
- `clave_ack`  in  1  consumer accepted `clave`. Sampled only while `clave_valida` is high.
- `clave`  out  16  last submitted PIN in BCD; first digit in [15:12]. Registered.
- `clave_valida`  out  1  PIN available; held until acknowledged. Registered.
- `digitos`  out  3  digits currently buffered, 0–4, for display.
- `error_tecla`  out  1  one-cycle pulse on a rejected key.
- `timeout`  out  1  one-cycle pulse when the inactivity timeout discards the buffer.

## Operation
- Internal state:
  - `buf[15:0]`, `cnt[2:0]` (drives `digitos`)
  - idle counter, width $clog2(TIMEOUT_CICLOS+1)
  - FSM states IDLE, CAPTURA, ENVIO.
- IDLE:
  - `buf`=0, `cnt`=0, keys ignored with no error.
  - `habilitar`=1 → CAPTURA.
- CAPTURA, when `tecla_valida`=1:
  - Digit with `cnt`<4: `buf` ← {`buf`[11:0], `tecla`}, `cnt`+1.
  - Digit with `cnt`=4: rejected. `error_tecla` pulses; `buf` and `cnt` unchanged.
  - Borrar with `cnt`>0: `buf` ← `buf`>>4, `cnt`−1.
  - Borrar with `cnt`=0: rejected (`error_tecla`).
  - Limpiar: `buf`=0, `cnt`=0. Never an error.
  - Enter with `cnt`=4: `clave` ← `buf`, go to ENVIO, then `buf`=0, `cnt`=0.
  - Enter with `cnt`<4: rejected (`error_tecla`), stay in CAPTURA.
  - 4'hD–4'hF: rejected (`error_tecla`), no state change.
- Idle counter:
  - Cleared on every `tecla_valida`, accepted or rejected.
  - Cleared whenever `cnt`=0 or the FSM is not in CAPTURA.
  - Otherwise increments each cycle.
  - On reaching TIMEOUT_CICLOS: `buf`=0, `cnt`=0, counter cleared, `timeout` pulses. FSM stays in CAPTURA.
- ENVIO:
  - `clave_valida`=1; `clave` held stable; keys ignored, no error.
  - `clave_ack`=1 → `clave_valida`=0, go to CAPTURA with an empty buffer.
  - The controller may then request a retry; it handles retry counting and lockout itself.
- Priority within one cycle, highest first:
  1. `habilitar`=0: go to IDLE, clear `buf`/`cnt`/counter, drop `clave_valida`; `clave` keeps its value.
  2. `tecla_valida`.
  3. Timeout.
- Key and timeout in the same cycle: the key is processed and the timeout is suppressed.

## Timing
- Reset (asynchronous):
  - State IDLE.
  - `clave`=16'h0000, `clave_valida`=0, `digitos`=0, `error_tecla`=0, `timeout`=0.
  - Idle counter 0.
- Reset mid-ENVIO drops `clave_valida` immediately, with no ack required.
- Key sampled at edge N → `digitos`, `error_tecla`, `clave`, `clave_valida` update at edge N, visible in cycle N+1. Latency is 1 cycle.
- `error_tecla` and `timeout` are each high for exactly one cycle per event.
- Handshake:
  - `clave_valida` rises in the cycle after the accepted enter.
  - It falls the cycle after the edge that samples `clave_ack`=1.
  - `clave_ack` asserted in the same cycle `clave_valida` first rises is a valid transfer.
  - Minimum `clave_valida` high time is 1 cycle.
- Timeout fires at the edge where the counter would reach TIMEOUT_CICLOS: exactly TIMEOUT_CICLOS idle cycles after the last key.
- Back-to-back keys on consecutive cycles are all processed; throughput is 1 key per cycle.

## Test plan
- `habilitar`=1, keys 2,4,6,8, C → `clave`=16'h2468 with `clave_valida`=1 the cycle after C. Hold `clave_ack`=0 for 5 cycles: `clave_valida` stays high and `clave` is stable. Then pulse ack → `clave_valida`=0 next cycle and `digitos`=0.
- Keys 1,2,3,A,4,5, C → `clave`=16'h1245. `digitos` sequence 1,2,3,2,3,4,0.
- Keys 9,9,9, C → `error_tecla` one-cycle pulse, no `clave_valida`, `digitos`=3. Then 1, 2:
  - 1 → `digitos`=4
  - 2 → `error_tecla` pulse, buffer still 16'h9991.
  - C → `clave`=16'h9991.
- TIMEOUT_CICLOS=8: key 7, then 7 idle cycles → no timeout. Eighth idle cycle → `timeout` pulse, `digitos`=0. Repeat with key 3 on the eighth idle cycle → `digitos`=2, no timeout pulse.
- Illegal keys and clears: 4'hE → `error_tecla` pulse; 4'hA with `cnt`=0 → error pulse; 4'hB with `cnt`=0 → no error.
- Aborts:
  - Deassert `habilitar` during ENVIO → `clave_valida`=0 next cycle, `clave` retains its value, keys ignored.
  - Assert `reset` mid-entry and mid-ENVIO → all outputs are at their reset values immediately.

Source files
------------

// File: rtl/ingreso_clave.sv
// Purpose : keypad front end; assembles a 4-digit BCD PIN from key strobes and hands it to the access controller.
// Latency : 1 cycle from a sampled key to digitos/error_tecla/clave/clave_valida.
// Backpressure: clave_valida holds (keys ignored) until clave_ack is sampled high.
//
// Ports:
//   clk, reset       clock and asynchronous active-high reset
//   habilitar        controller accepts PIN attempts; low forces IDLE
//   tecla_valida     one-cycle key strobe, tecla valid with it
//   tecla[3:0]       0-9 digit, A backspace, B clear, C enter, D-F illegal
//   clave_ack        consumer took clave (only looked at while clave_valida)
//   clave[15:0]      last submitted PIN, first digit in [15:12]
//   clave_valida     PIN available, held until acknowledged
//   digitos[2:0]     digits currently buffered (0-4)
//   error_tecla      one-cycle pulse on a rejected key
//   timeout          one-cycle pulse when the idle timeout discards the buffer
module ingreso_clave #(
    parameter int TIMEOUT_CICLOS = 1000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        habilitar,
    input  logic        tecla_valida,
    input  logic [3:0]  tecla,
    input  logic        clave_ack,
    output logic [15:0] clave,
    output logic        clave_valida,
    output logic [2:0]  digitos,
    output logic        error_tecla,
    output logic        timeout
);

    localparam int CW = $clog2(TIMEOUT_CICLOS + 1);
    // The counter fires on the edge where it would reach TIMEOUT_CICLOS,
    // i.e. when it currently holds TIMEOUT_CICLOS-1.
    localparam logic [CW-1:0] CTR_LAST = CW'(TIMEOUT_CICLOS - 1);
    localparam logic [CW-1:0] CTR_ONE  = CW'(1);

    localparam logic [3:0] TECLA_BORRAR  = 4'hA;
    localparam logic [3:0] TECLA_LIMPIAR = 4'hB;
    localparam logic [3:0] TECLA_ENTER   = 4'hC;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURA = 2'd1,
        ENVIO   = 2'd2
    } estado_t;

    estado_t        estado_q, estado_d;
    logic [15:0]    buf_q, buf_d;
    logic [2:0]     cnt_q, cnt_d;
    logic [CW-1:0]  ctr_q, ctr_d;
    logic [15:0]    clave_q, clave_d;
    logic           valida_q, valida_d;
    logic           error_q, error_d;
    logic           timeout_q, timeout_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            estado_q  <= IDLE;
            buf_q     <= 16'h0000;
            cnt_q     <= 3'd0;
            ctr_q     <= '0;
            clave_q   <= 16'h0000;
            valida_q  <= 1'b0;
            error_q   <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            estado_q  <= estado_d;
            buf_q     <= buf_d;
            cnt_q     <= cnt_d;
            ctr_q     <= ctr_d;
            clave_q   <= clave_d;
            valida_q  <= valida_d;
            error_q   <= error_d;
            timeout_q <= timeout_d;
        end
    end

    always_comb begin
        estado_d  = estado_q;
        buf_d     = buf_q;
        cnt_d     = cnt_q;
        // Counter only survives a cycle in CAPTURA with digits buffered and no key.
        ctr_d     = '0;
        clave_d   = clave_q;
        valida_d  = valida_q;
        error_d   = 1'b0;
        timeout_d = 1'b0;

        if (!habilitar) begin
            // Abort wins over everything; clave keeps the last submitted PIN.
            estado_d = IDLE;
            buf_d    = 16'h0000;
            cnt_d    = 3'd0;
            valida_d = 1'b0;
        end else begin
            case (estado_q)
                IDLE: begin
                    buf_d    = 16'h0000;
                    cnt_d    = 3'd0;
                    estado_d = CAPTURA;
                end

                CAPTURA: begin
                    if (tecla_valida) begin
                        // A key of any kind restarts the idle count and
                        // suppresses a timeout due in the same cycle.
                        if (tecla <= 4'd9) begin
                            if (cnt_q < 3'd4) begin
                                buf_d = {buf_q[11:0], tecla};
                                cnt_d = cnt_q + 3'd1;
                            end else begin
                                error_d = 1'b1;
                            end
                        end else if (tecla == TECLA_BORRAR) begin
                            if (cnt_q != 3'd0) begin
                                buf_d = {4'h0, buf_q[15:4]};
                                cnt_d = cnt_q - 3'd1;
                            end else begin
                                error_d = 1'b1;
                            end
                        end else if (tecla == TECLA_LIMPIAR) begin
                            buf_d = 16'h0000;
                            cnt_d = 3'd0;
                        end else if (tecla == TECLA_ENTER) begin
                            if (cnt_q == 3'd4) begin
                                clave_d  = buf_q;
                                valida_d = 1'b1;
                                estado_d = ENVIO;
                                buf_d    = 16'h0000;
                                cnt_d    = 3'd0;
                            end else begin
                                error_d = 1'b1;
                            end
                        end else begin
                            error_d = 1'b1;
                        end
                    end else if (cnt_q != 3'd0) begin
                        if (ctr_q == CTR_LAST) begin
                            buf_d     = 16'h0000;
                            cnt_d     = 3'd0;
                            timeout_d = 1'b1;
                        end else begin
                            ctr_d = ctr_q + CTR_ONE;
                        end
                    end
                end

                ENVIO: begin
                    // Keys are dropped silently while the PIN is on offer.
                    if (clave_ack) begin
                        valida_d = 1'b0;
                        estado_d = CAPTURA;
                    end
                end

                default: begin
                    estado_d = IDLE;
                    buf_d    = 16'h0000;
                    cnt_d    = 3'd0;
                    valida_d = 1'b0;
                end
            endcase
        end
    end

    assign clave        = clave_q;
    assign clave_valida = valida_q;
    assign digitos      = cnt_q;
    assign error_tecla  = error_q;
    assign timeout      = timeout_q;

endmodule

// File: tb/tb_ingreso_clave.sv
module tb_ingreso_clave;

    logic        clk = 1'b0;
    logic        reset;
    logic        habilitar;
    logic        tecla_valida;
    logic [3:0]  tecla;
    logic        clave_ack;
    logic [15:0] clave;
    logic        clave_valida;
    logic [2:0]  digitos;
    logic        error_tecla;
    logic        timeout;

    int vectors = 0;
    int miscompares = 0;

    ingreso_clave #(.TIMEOUT_CICLOS(8)) dut (
        .clk          (clk),
        .reset        (reset),
        .habilitar    (habilitar),
        .tecla_valida (tecla_valida),
        .tecla        (tecla),
        .clave_ack    (clave_ack),
        .clave        (clave),
        .clave_valida (clave_valida),
        .digitos      (digitos),
        .error_tecla  (error_tecla),
        .timeout      (timeout)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not end, got running expected finished");
        $fatal(1, "watchdog");
    end

    // Advance one edge; outputs are sampled 1 time unit after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic press(input logic [3:0] k);
        tecla_valida = 1'b1;
        tecla        = k;
        step();
        tecla_valida = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; habilitar = 1'b0; tecla_valida = 1'b0; tecla = 4'h0; clave_ack = 1'b0;
        #22;
        vectors++;
        if ({clave, clave_valida, digitos, error_tecla, timeout} !== 22'h0) begin
            miscompares++;
            $display("FAIL reset_outputs: got clave=%h val=%b dig=%0d err=%b to=%b expected all zero",
                     clave, clave_valida, digitos, error_tecla, timeout);
        end
        step();
        reset = 1'b0;
        habilitar = 1'b1;
        step(); // IDLE -> CAPTURA
    endtask

    task automatic test_pin_basic();
        logic [3:0] keys [4];
        keys = '{4'd2, 4'd4, 4'd6, 4'd8};
        for (int i = 0; i < 4; i++) begin
            press(keys[i]);
            vectors++;
            if (digitos !== 3'(i + 1)) begin
                miscompares++;
                $display("FAIL basic_digitos[%0d]: got %0d expected %0d", i, digitos, i + 1);
            end
        end
        press(4'hC);
        vectors++;
        if (clave_valida !== 1'b1 || clave !== 16'h2468 || digitos !== 3'd0) begin
            miscompares++;
            $display("FAIL basic_enter: got val=%b clave=%h dig=%0d expected val=1 clave=2468 dig=0",
                     clave_valida, clave, digitos);
        end
        for (int i = 0; i < 5; i++) begin
            step();
            vectors++;
            if (clave_valida !== 1'b1 || clave !== 16'h2468) begin
                miscompares++;
                $display("FAIL basic_hold[%0d]: got val=%b clave=%h expected val=1 clave=2468",
                         i, clave_valida, clave);
            end
        end
        clave_ack = 1'b1;
        step();
        clave_ack = 1'b0;
        vectors++;
        if (clave_valida !== 1'b0 || digitos !== 3'd0 || clave !== 16'h2468) begin
            miscompares++;
            $display("FAIL basic_ack: got val=%b dig=%0d clave=%h expected val=0 dig=0 clave=2468",
                     clave_valida, digitos, clave);
        end
    endtask

    task automatic test_backspace();
        logic [3:0] keys [7];
        logic [2:0] exp_dig [7];
        keys    = '{4'd1, 4'd2, 4'd3, 4'hA, 4'd4, 4'd5, 4'hC};
        exp_dig = '{3'd1, 3'd2, 3'd3, 3'd2, 3'd3, 3'd4, 3'd0};
        for (int i = 0; i < 7; i++) begin
            press(keys[i]);
            vectors++;
            if (digitos !== exp_dig[i] || error_tecla !== 1'b0) begin
                miscompares++;
                $display("FAIL bksp_digitos[%0d]: got dig=%0d err=%b expected dig=%0d err=0",
                         i, digitos, error_tecla, exp_dig[i]);
            end
        end
        vectors++;
        if (clave_valida !== 1'b1 || clave !== 16'h1245) begin
            miscompares++;
            $display("FAIL bksp_clave: got val=%b clave=%h expected val=1 clave=1245", clave_valida, clave);
        end
        // Ack in the very first cycle clave_valida is high.
        clave_ack = 1'b1;
        step();
        clave_ack = 1'b0;
        vectors++;
        if (clave_valida !== 1'b0) begin
            miscompares++;
            $display("FAIL bksp_fast_ack: got val=%b expected 0", clave_valida);
        end
    endtask

    task automatic test_errors();
        press(4'd9); press(4'd9); press(4'd9);
        press(4'hC);
        vectors++;
        if (error_tecla !== 1'b1 || clave_valida !== 1'b0 || digitos !== 3'd3) begin
            miscompares++;
            $display("FAIL err_short_enter: got err=%b val=%b dig=%0d expected err=1 val=0 dig=3",
                     error_tecla, clave_valida, digitos);
        end
        step();
        vectors++;
        if (error_tecla !== 1'b0) begin
            miscompares++;
            $display("FAIL err_pulse_width: got err=%b expected 0", error_tecla);
        end
        press(4'd1);
        vectors++;
        if (digitos !== 3'd4 || error_tecla !== 1'b0) begin
            miscompares++;
            $display("FAIL err_fourth: got dig=%0d err=%b expected dig=4 err=0", digitos, error_tecla);
        end
        press(4'd2);
        vectors++;
        if (digitos !== 3'd4 || error_tecla !== 1'b1) begin
            miscompares++;
            $display("FAIL err_fifth: got dig=%0d err=%b expected dig=4 err=1", digitos, error_tecla);
        end
        press(4'hC);
        vectors++;
        if (clave !== 16'h9991 || clave_valida !== 1'b1 || error_tecla !== 1'b0) begin
            miscompares++;
            $display("FAIL err_clave: got clave=%h val=%b err=%b expected clave=9991 val=1 err=0",
                     clave, clave_valida, error_tecla);
        end
        clave_ack = 1'b1;
        step();
        clave_ack = 1'b0;
    endtask

    task automatic test_timeout();
        press(4'd7);
        for (int i = 0; i < 7; i++) begin
            step();
            vectors++;
            if (timeout !== 1'b0 || digitos !== 3'd1) begin
                miscompares++;
                $display("FAIL to_early[%0d]: got to=%b dig=%0d expected to=0 dig=1", i, timeout, digitos);
            end
        end
        step();
        vectors++;
        if (timeout !== 1'b1 || digitos !== 3'd0) begin
            miscompares++;
            $display("FAIL to_fire: got to=%b dig=%0d expected to=1 dig=0", timeout, digitos);
        end
        step();
        vectors++;
        if (timeout !== 1'b0) begin
            miscompares++;
            $display("FAIL to_pulse_width: got to=%b expected 0", timeout);
        end
        press(4'd7);
        repeat (7) step();
        press(4'd3);
        vectors++;
        if (timeout !== 1'b0 || digitos !== 3'd2) begin
            miscompares++;
            $display("FAIL to_suppressed: got to=%b dig=%0d expected to=0 dig=2", timeout, digitos);
        end
        step();
        vectors++;
        if (timeout !== 1'b0 || digitos !== 3'd2) begin
            miscompares++;
            $display("FAIL to_restart: got to=%b dig=%0d expected to=0 dig=2", timeout, digitos);
        end
        press(4'hB);
    endtask

    task automatic test_illegal();
        press(4'hE);
        vectors++;
        if (error_tecla !== 1'b1 || digitos !== 3'd0) begin
            miscompares++;
            $display("FAIL ill_E: got err=%b dig=%0d expected err=1 dig=0", error_tecla, digitos);
        end
        press(4'hA);
        vectors++;
        if (error_tecla !== 1'b1) begin
            miscompares++;
            $display("FAIL ill_bksp_empty: got err=%b expected 1", error_tecla);
        end
        press(4'hB);
        vectors++;
        if (error_tecla !== 1'b0 || digitos !== 3'd0) begin
            miscompares++;
            $display("FAIL ill_clear_empty: got err=%b dig=%0d expected err=0 dig=0", error_tecla, digitos);
        end
        press(4'd5); press(4'd6);
        press(4'hB);
        vectors++;
        if (error_tecla !== 1'b0 || digitos !== 3'd0) begin
            miscompares++;
            $display("FAIL ill_clear_full: got err=%b dig=%0d expected err=0 dig=0", error_tecla, digitos);
        end
    endtask

    task automatic test_abort();
        press(4'd1); press(4'd2); press(4'd3); press(4'd4);
        press(4'hC);
        press(4'd5); // ignored while PIN is on offer
        vectors++;
        if (clave_valida !== 1'b1 || clave !== 16'h1234 || digitos !== 3'd0 || error_tecla !== 1'b0) begin
            miscompares++;
            $display("FAIL abort_envio_key: got val=%b clave=%h dig=%0d err=%b expected val=1 clave=1234 dig=0 err=0",
                     clave_valida, clave, digitos, error_tecla);
        end
        habilitar = 1'b0;
        step();
        vectors++;
        if (clave_valida !== 1'b0 || clave !== 16'h1234) begin
            miscompares++;
            $display("FAIL abort_disable: got val=%b clave=%h expected val=0 clave=1234", clave_valida, clave);
        end
        press(4'd6);
        vectors++;
        if (digitos !== 3'd0 || error_tecla !== 1'b0) begin
            miscompares++;
            $display("FAIL abort_idle_key: got dig=%0d err=%b expected dig=0 err=0", digitos, error_tecla);
        end
        habilitar = 1'b1;
        step();
        press(4'd6);
        vectors++;
        if (digitos !== 3'd1) begin
            miscompares++;
            $display("FAIL abort_reenable: got dig=%0d expected 1", digitos);
        end
    endtask

    task automatic test_reset_mid();
        press(4'd7);
        #2 reset = 1'b1;
        #1;
        vectors++;
        if ({clave, clave_valida, digitos, error_tecla, timeout} !== 22'h0) begin
            miscompares++;
            $display("FAIL rst_mid_entry: got clave=%h val=%b dig=%0d err=%b to=%b expected all zero",
                     clave, clave_valida, digitos, error_tecla, timeout);
        end
        step();
        reset = 1'b0;
        step();
        press(4'd4); press(4'd3); press(4'd2); press(4'd1);
        press(4'hC);
        vectors++;
        if (clave_valida !== 1'b1 || clave !== 16'h4321) begin
            miscompares++;
            $display("FAIL rst_refill: got val=%b clave=%h expected val=1 clave=4321", clave_valida, clave);
        end
        #2 reset = 1'b1;
        #1;
        vectors++;
        if (clave_valida !== 1'b0 || clave !== 16'h0000 || digitos !== 3'd0) begin
            miscompares++;
            $display("FAIL rst_mid_envio: got val=%b clave=%h dig=%0d expected val=0 clave=0000 dig=0",
                     clave_valida, clave, digitos);
        end
        step();
        reset = 1'b0;
    endtask

    initial begin
        test_reset();
        test_pin_basic();
        test_backspace();
        test_errors();
        test_timeout();
        test_illegal();
        test_abort();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
